pipeline_hazard_ctrl: RTL and testbench

//  Drives en/flush of the four uDLX pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB) and pc_en.

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 33 +++
 rtl/pipeline_hazard_ctrl_load_use_detect.sv | 26 ++
 rtl/pipeline_hazard_ctrl.sv | 165 ++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared definitions for the uDLX pipeline hazard controller:
// FSM state encodings and the bundle of pipeline-register controls.
package pipeline_hazard_ctrl_pkg;

  // FSM state encodings (kept as plain constants for legacy tools)
  localparam logic [1:0] STATE_RUN      = 2'd0;
  localparam logic [1:0] STATE_MEM_WAIT = 2'd1;
  localparam logic [1:0] STATE_SHADOW   = 2'd2;

  // One enable and one bubble-insert per pipeline register, plus the PC enable
  typedef struct packed {
    logic pc_en;
    logic if_id_en;
    logic id_ex_en;
    logic ex_mem_en;
    logic mem_wb_en;
    logic if_id_flush;
    logic id_ex_flush;
    logic ex_mem_flush;
    logic mem_wb_flush;
  } hazard_ctl_t;

  // Everything advancing, no bubbles
  localparam hazard_ctl_t CTL_RUN = '{pc_en: 1'b1, if_id_en: 1'b1, id_ex_en: 1'b1,
                                      ex_mem_en: 1'b1, mem_wb_en: 1'b1, default: 1'b0};

  // Data-memory freeze: front of the pipe holds, MEM/WB receives a bubble
  localparam hazard_ctl_t CTL_FREEZE = '{mem_wb_en: 1'b1, mem_wb_flush: 1'b1, default: 1'b0};

  // Held in reset: nothing moves, nothing is flushed
  localparam hazard_ctl_t CTL_OFF = '{default: 1'b0};

endpackage

// File: rtl/pipeline_hazard_ctrl_load_use_detect.sv
// Load-use RAW detector: flags when the instruction in ID reads a register
// that the load currently leaving ID/EX will write. Register 0 is hardwired
// zero and never creates a dependency.
module load_use_detect #(
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic [REG_ADDR_WIDTH-1:0] id_rd_addr1,
  input  logic [REG_ADDR_WIDTH-1:0] id_rd_addr2,
  input  logic                      id_use_r1,
  input  logic                      id_use_r2,
  input  logic                      ex_mem_rd_en,
  input  logic [REG_ADDR_WIDTH-1:0] ex_wr_addr,
  input  logic                      ex_wr_en,
  output logic                      load_use
);

  logic load_writes_reg;
  logic match_r1;
  logic match_r2;

  assign load_writes_reg = ex_mem_rd_en & ex_wr_en & (ex_wr_addr != '0);
  assign match_r1        = id_use_r1 & (id_rd_addr1 == ex_wr_addr);
  assign match_r2        = id_use_r2 & (id_rd_addr2 == ex_wr_addr);
  assign load_use        = load_writes_reg & (match_r1 | match_r2);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage uDLX core. Generates enables
// and bubble inserts for the four pipeline registers and the PC, resolving
// data-memory waits, taken branches/jumps and load-use hazards in that
// priority order. Also keeps saturating stall/flush counters and a sticky
// memory-timeout flag.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int BRANCH_SHADOW  = 1,
  parameter int MEM_TIMEOUT    = 255,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [REG_ADDR_WIDTH-1:0] id_rd_addr1,
  input  logic [REG_ADDR_WIDTH-1:0] id_rd_addr2,
  input  logic                      id_use_r1,
  input  logic                      id_use_r2,
  input  logic                      ex_mem_rd_en,
  input  logic [REG_ADDR_WIDTH-1:0] ex_wr_addr,
  input  logic                      ex_wr_en,
  input  logic                      ex_redirect,
  input  logic                      mem_req,
  input  logic                      dmem_ack,
  output logic                      pc_en,
  output logic                      if_id_en,
  output logic                      id_ex_en,
  output logic                      ex_mem_en,
  output logic                      mem_wb_en,
  output logic                      if_id_flush,
  output logic                      id_ex_flush,
  output logic                      ex_mem_flush,
  output logic                      mem_wb_flush,
  output logic [CNT_WIDTH-1:0]      stall_cnt,
  output logic [CNT_WIDTH-1:0]      flush_cnt,
  output logic                      mem_err
);

  localparam int TIMER_W = $clog2(MEM_TIMEOUT + 1);

  logic [1:0]           state_q, state_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic [1:0]           shadow_q, shadow_d;
  logic                 mem_err_q, mem_err_d;
  logic [CNT_WIDTH-1:0] stall_cnt_q, flush_cnt_q;
  logic                 redirect_evt;
  logic                 load_use;
  hazard_ctl_t          ctl;

  load_use_detect #(
    .REG_ADDR_WIDTH(REG_ADDR_WIDTH)
  ) u_load_use_detect (
    .id_rd_addr1 (id_rd_addr1),
    .id_rd_addr2 (id_rd_addr2),
    .id_use_r1   (id_use_r1),
    .id_use_r2   (id_use_r2),
    .ex_mem_rd_en(ex_mem_rd_en),
    .ex_wr_addr  (ex_wr_addr),
    .ex_wr_en    (ex_wr_en),
    .load_use    (load_use)
  );

  // Next-state and pipeline controls from current state and hazard inputs
  always_comb begin
    ctl          = CTL_RUN;
    state_d      = state_q;
    timer_d      = timer_q;
    shadow_d     = shadow_q;
    mem_err_d    = mem_err_q;
    redirect_evt = 1'b0;

    if (state_q == STATE_MEM_WAIT) begin
      // Only the memory can release the freeze; EX hazards re-present afterwards
      if (dmem_ack) begin
        state_d = STATE_RUN;
        timer_d = '0;
      end else if (timer_q == TIMER_W'(MEM_TIMEOUT)) begin
        ctl              = CTL_FREEZE;
        ctl.ex_mem_en    = 1'b1;
        ctl.ex_mem_flush = 1'b1;
        mem_err_d        = 1'b1;
        state_d          = STATE_RUN;
        timer_d          = '0;
      end else begin
        ctl     = CTL_FREEZE;
        timer_d = timer_q + TIMER_W'(1);
      end
    end else begin
      // RUN or SHADOW: shadow bubbles first, then let higher-priority events override
      if (state_q == STATE_SHADOW) begin
        ctl.if_id_flush = 1'b1;
        if (shadow_q <= 2'd1) begin
          state_d  = STATE_RUN;
          shadow_d = '0;
        end else begin
          shadow_d = shadow_q - 2'd1;
        end
      end

      if (mem_req && !dmem_ack) begin
        ctl      = CTL_FREEZE;
        state_d  = STATE_MEM_WAIT;
        timer_d  = TIMER_W'(1);
        shadow_d = '0;
      end else if (ex_redirect) begin
        ctl.if_id_flush = 1'b1;
        ctl.id_ex_flush = 1'b1;
        redirect_evt    = 1'b1;
        if (BRANCH_SHADOW > 0) begin
          state_d  = STATE_SHADOW;
          shadow_d = 2'(BRANCH_SHADOW);
        end else begin
          state_d  = STATE_RUN;
        end
      end else if (load_use) begin
        // The load moves on to EX/MEM, so a single bubble resolves the hazard
        ctl.pc_en       = 1'b0;
        ctl.if_id_en    = 1'b0;
        ctl.id_ex_flush = 1'b1;
      end
    end

    if (!rst_n) begin
      ctl = CTL_OFF;
    end
  end

  // State, timers, sticky error and saturating performance counters
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= STATE_RUN;
      timer_q     <= '0;
      shadow_q    <= '0;
      mem_err_q   <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      shadow_q  <= shadow_d;
      mem_err_q <= mem_err_d;
      if (!ctl.pc_en && (stall_cnt_q != {CNT_WIDTH{1'b1}})) begin
        stall_cnt_q <= stall_cnt_q + CNT_WIDTH'(1);
      end
      if (redirect_evt && (flush_cnt_q != {CNT_WIDTH{1'b1}})) begin
        flush_cnt_q <= flush_cnt_q + CNT_WIDTH'(1);
      end
    end
  end

  assign pc_en        = ctl.pc_en;
  assign if_id_en     = ctl.if_id_en;
  assign id_ex_en     = ctl.id_ex_en;
  assign ex_mem_en    = ctl.ex_mem_en;
  assign mem_wb_en    = ctl.mem_wb_en;
  assign if_id_flush  = ctl.if_id_flush;
  assign id_ex_flush  = ctl.id_ex_flush;
  assign ex_mem_flush = ctl.ex_mem_flush;
  assign mem_wb_flush = ctl.mem_wb_flush;
  assign stall_cnt    = stall_cnt_q;
  assign flush_cnt    = flush_cnt_q;
  assign mem_err      = mem_err_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed testbench for pipeline_hazard_ctrl (BRANCH_SHADOW=1, MEM_TIMEOUT=4).
// Control outputs are compared as a 9-bit vector:
// {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
//  if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush}
module tb_pipeline_hazard_ctrl;

  localparam logic [8:0] EXP_RST    = 9'b00000_0000;
  localparam logic [8:0] EXP_RUN    = 9'b11111_0000;
  localparam logic [8:0] EXP_LU     = 9'b00111_0100;
  localparam logic [8:0] EXP_REDIR  = 9'b11111_1100;
  localparam logic [8:0] EXP_SHADOW = 9'b11111_1000;
  localparam logic [8:0] EXP_FREEZE = 9'b00001_0001;
  localparam logic [8:0] EXP_ABORT  = 9'b00011_0011;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  id_rd_addr1, id_rd_addr2, ex_wr_addr;
  logic        id_use_r1, id_use_r2, ex_mem_rd_en, ex_wr_en;
  logic        ex_redirect, mem_req, dmem_ack;
  logic        pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic        if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush;
  logic [31:0] stall_cnt, flush_cnt;
  logic        mem_err;
  logic [8:0]  ctl;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(
    .REG_ADDR_WIDTH(5),
    .BRANCH_SHADOW (1),
    .MEM_TIMEOUT   (4),
    .CNT_WIDTH     (32)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .id_rd_addr1 (id_rd_addr1),
    .id_rd_addr2 (id_rd_addr2),
    .id_use_r1   (id_use_r1),
    .id_use_r2   (id_use_r2),
    .ex_mem_rd_en(ex_mem_rd_en),
    .ex_wr_addr  (ex_wr_addr),
    .ex_wr_en    (ex_wr_en),
    .ex_redirect (ex_redirect),
    .mem_req     (mem_req),
    .dmem_ack    (dmem_ack),
    .pc_en       (pc_en),
    .if_id_en    (if_id_en),
    .id_ex_en    (id_ex_en),
    .ex_mem_en   (ex_mem_en),
    .mem_wb_en   (mem_wb_en),
    .if_id_flush (if_id_flush),
    .id_ex_flush (id_ex_flush),
    .ex_mem_flush(ex_mem_flush),
    .mem_wb_flush(mem_wb_flush),
    .stall_cnt   (stall_cnt),
    .flush_cnt   (flush_cnt),
    .mem_err     (mem_err)
  );

  assign ctl = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush};

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: inputs already set; sample controls mid-cycle, then advance
  task automatic cyc(input string tag, input logic [8:0] exp);
    @(negedge clk);
    $display("cycle %-12s ctl=%b exp=%b stall=%0d flush=%0d err=%0d",
             tag, ctl, exp, stall_cnt, flush_cnt, mem_err);
    check_val(tag, {23'd0, ctl}, {23'd0, exp});
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    id_rd_addr1 = '0; id_rd_addr2 = '0; ex_wr_addr = '0;
    id_use_r1 = 0; id_use_r2 = 0; ex_mem_rd_en = 0; ex_wr_en = 0;
    ex_redirect = 0; mem_req = 0; dmem_ack = 0;
  endtask

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    @(posedge clk); #1;
    cyc("reset", EXP_RST);
    rst_n = 1'b1;

    // Reset state
    cyc("idle", EXP_RUN);
    check_val("rst_stall_cnt", stall_cnt, 32'd0);
    check_val("rst_flush_cnt", flush_cnt, 32'd0);
    check_val("rst_mem_err", {31'd0, mem_err}, 32'd0);

    // Load-use through source 1: one bubble, then normal flow
    ex_mem_rd_en = 1; ex_wr_en = 1; ex_wr_addr = 5'd3; id_rd_addr1 = 5'd3; id_use_r1 = 1;
    cyc("lu_r1", EXP_LU);
    clear_inputs();
    cyc("lu_r1_next", EXP_RUN);
    check_val("lu_stall_cnt", stall_cnt, 32'd1);

    // Destination r0 never stalls
    ex_mem_rd_en = 1; ex_wr_en = 1; ex_wr_addr = 5'd0; id_rd_addr1 = 5'd0; id_use_r1 = 1;
    cyc("lu_r0", EXP_RUN);
    // Match on source 2
    clear_inputs();
    ex_mem_rd_en = 1; ex_wr_en = 1; ex_wr_addr = 5'd7; id_rd_addr2 = 5'd7; id_use_r2 = 1;
    cyc("lu_r2", EXP_LU);
    // Same address but source 2 not read
    id_use_r2 = 0;
    cyc("lu_r2_unused", EXP_RUN);
    // Not a load
    id_use_r2 = 1; ex_mem_rd_en = 0;
    cyc("lu_not_load", EXP_RUN);
    clear_inputs();
    check_val("lu2_stall_cnt", stall_cnt, 32'd2);

    // Redirect with one shadow cycle
    ex_redirect = 1;
    cyc("redir", EXP_REDIR);
    ex_redirect = 0;
    cyc("shadow", EXP_SHADOW);
    cyc("post_shadow", EXP_RUN);
    check_val("redir_flush_cnt", flush_cnt, 32'd1);

    // Redirect beats load-use
    ex_redirect = 1; ex_mem_rd_en = 1; ex_wr_en = 1; ex_wr_addr = 5'd4;
    id_rd_addr1 = 5'd4; id_use_r1 = 1;
    cyc("redir_over_lu", EXP_REDIR);
    clear_inputs();
    cyc("shadow2", EXP_SHADOW);
    check_val("redir2_flush_cnt", flush_cnt, 32'd2);
    check_val("redir2_stall_cnt", stall_cnt, 32'd2);

    // Memory wait: ack on the fourth cycle, redirect during freeze ignored
    mem_req = 1;
    cyc("mw_0", EXP_FREEZE);
    ex_redirect = 1;
    cyc("mw_1_redir", EXP_FREEZE);
    ex_redirect = 0;
    cyc("mw_2", EXP_FREEZE);
    dmem_ack = 1;
    cyc("mw_ack", EXP_RUN);
    clear_inputs();
    cyc("mw_after", EXP_RUN);
    check_val("mw_stall_cnt", stall_cnt, 32'd5);
    check_val("mw_flush_cnt", flush_cnt, 32'd2);

    // Request with immediate ack: no stall
    mem_req = 1; dmem_ack = 1;
    cyc("mem_fast", EXP_RUN);
    clear_inputs();

    // Timeout: four wait cycles then abort
    mem_req = 1;
    for (int i = 0; i < 4; i++) cyc($sformatf("to_wait%0d", i), EXP_FREEZE);
    check_val("to_err_before", {31'd0, mem_err}, 32'd0);
    cyc("to_abort", EXP_ABORT);
    mem_req = 0;
    cyc("to_after", EXP_RUN);
    check_val("to_mem_err", {31'd0, mem_err}, 32'd1);
    check_val("to_stall_cnt", stall_cnt, 32'd10);

    // Memory wait arriving in the branch shadow overrides it
    ex_redirect = 1;
    cyc("sh_redir", EXP_REDIR);
    ex_redirect = 0; mem_req = 1;
    cyc("sh_mw_0", EXP_FREEZE);
    cyc("sh_mw_1", EXP_FREEZE);
    dmem_ack = 1;
    cyc("sh_mw_ack", EXP_RUN);
    clear_inputs();
    check_val("sh_flush_cnt", flush_cnt, 32'd3);
    check_val("sh_stall_cnt", stall_cnt, 32'd12);
    check_val("sh_mem_err", {31'd0, mem_err}, 32'd1);

    // Reset in the middle of a memory wait
    mem_req = 1;
    cyc("rm_mw_0", EXP_FREEZE);
    cyc("rm_mw_1", EXP_FREEZE);
    rst_n = 0;
    cyc("rm_reset", EXP_RST);
    rst_n = 1; mem_req = 0;
    cyc("rm_run", EXP_RUN);
    check_val("rm_stall_cnt", stall_cnt, 32'd0);
    check_val("rm_flush_cnt", flush_cnt, 32'd0);
    check_val("rm_mem_err", {31'd0, mem_err}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
